// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_ctrl
// Description : Fetch stage and IF/ID pipeline register of the 16-bit,
//               8-register pipelined CPU. Holds the PC, drives the
//               instruction-memory address and captures fetched instructions
//               into IF/ID. Each edge resolves, in strict priority order,
//               redirect (FLUSH), data-hazard stall (STALL), memory wait
//               (WAIT) and normal fetch (RUN).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i            in   clock, rising-edge
//   rst_i            in   synchronous active-high reset
//   dhz_i            in   data hazard (stall request)
//   chz_i            in   control hazard (flush / redirect request)
//   pcsrc_i          in   redirect selects branch_target_i when 1
//   branch_target_i  in   branch destination
//   jump_target_i    in   jump destination (redirect with pcsrc_i = 0)
//   imem_addr_o      out  instruction memory address (= pc_o)
//   imem_data_i      in   instruction read data, same cycle
//   imem_valid_i     in   imem_data_i valid this cycle
//   pc_o             out  current PC register
//   ifid_instr_o     out  IF/ID instruction
//   ifid_pc_plus_o   out  IF/ID fetch PC + PC_INC
//   ifid_valid_o     out  IF/ID holds a real instruction
//   ifid_rs_o        out  ifid_instr_o[12:10]
//   ifid_rt_o        out  ifid_instr_o[9:7]
//   fetch_state_o    out  action at last edge: 0 RUN, 1 STALL, 2 FLUSH, 3 WAIT
//   stall_cnt_o      out  saturating STALL edge counter
//   flush_cnt_o      out  saturating FLUSH edge counter
// Configuration:
//   FETCH_PERF_EN    when defined, stall/flush counters are implemented;
//                    otherwise both counter ports are tied to zero.
// ============================================================================
module if_stage_ctrl #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter int                 PC_INC    = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dhz_i,
  input  logic               chz_i,
  input  logic               pcsrc_i,
  input  logic [PC_W-1:0]    branch_target_i,
  input  logic [PC_W-1:0]    jump_target_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               imem_valid_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_plus_o,
  output logic               ifid_valid_o,
  output logic [2:0]         ifid_rs_o,
  output logic [2:0]         ifid_rt_o,
  output logic [1:0]         fetch_state_o,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } fetch_state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  // Registered state
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc_plus;
  logic               ifid_valid;
  fetch_state_t       state;

  // Next-state values
  logic [PC_W-1:0]    pc_next;
  logic [INSTR_W-1:0] ifid_instr_next;
  logic [PC_W-1:0]    ifid_pc_plus_next;
  logic               ifid_valid_next;
  fetch_state_t       state_next;

  // Sequential PC increment; the adder naturally wraps modulo 2^PC_W.
  logic [PC_W-1:0]    pc_plus;
  assign pc_plus = pc + PC_STEP;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc           <= RESET_PC;
      ifid_instr   <= NOP_INSTR;
      ifid_pc_plus <= '0;
      ifid_valid   <= 1'b0;
      state        <= ST_RUN;
    end else begin
      pc           <= pc_next;
      ifid_instr   <= ifid_instr_next;
      ifid_pc_plus <= ifid_pc_plus_next;
      ifid_valid   <= ifid_valid_next;
      state        <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: redirect > stall > memory wait > fetch
  // --------------------------------------------------------------------------
  always_comb begin
    pc_next           = pc;
    ifid_instr_next   = ifid_instr;
    ifid_pc_plus_next = ifid_pc_plus;
    ifid_valid_next   = ifid_valid;
    state_next        = ST_RUN;

    if (chz_i) begin
      // Redirect squashes whatever was fetched this cycle.
      state_next        = ST_FLUSH;
      pc_next           = pcsrc_i ? branch_target_i : jump_target_i;
      ifid_instr_next   = NOP_INSTR;
      ifid_pc_plus_next = '0;
      ifid_valid_next   = 1'b0;
    end else if (dhz_i) begin
      // Freeze PC and IF/ID so the decoder re-presents the same instruction.
      state_next = ST_STALL;
    end else if (!imem_valid_i) begin
      // Memory not ready: refetch the same address, push a bubble forward.
      state_next        = ST_WAIT;
      ifid_instr_next   = NOP_INSTR;
      ifid_pc_plus_next = '0;
      ifid_valid_next   = 1'b0;
    end else begin
      state_next        = ST_RUN;
      pc_next           = pc_plus;
      ifid_instr_next   = imem_data_i;
      ifid_pc_plus_next = pc_plus;
      ifid_valid_next   = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state_next == ST_STALL && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (state_next == ST_FLUSH && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc_o           = pc;
  assign imem_addr_o    = pc;
  assign ifid_instr_o   = ifid_instr;
  assign ifid_pc_plus_o = ifid_pc_plus;
  assign ifid_valid_o   = ifid_valid;
  // Register slices only, so no combinational path from the hazard inputs.
  assign ifid_rs_o      = ifid_instr[12:10];
  assign ifid_rt_o      = ifid_instr[9:7];
  assign fetch_state_o  = state;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage_ctrl
// Description : Self-checking bench for if_stage_ctrl. Directed vectors with
//               hand-computed post-edge expectations, plus short hand-written
//               sequences for reset priority and fetch latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dhz, chz, pcsrc, imem_valid;
  logic [15:0] branch_target, jump_target, imem_data;
  logic [15:0] imem_addr, pc, ifid_instr, ifid_pc_plus;
  logic        ifid_valid;
  logic [2:0]  ifid_rs, ifid_rt;
  logic [1:0]  fetch_state;
  logic [15:0] stall_cnt, flush_cnt;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  if_stage_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dhz_i           (dhz),
    .chz_i           (chz),
    .pcsrc_i         (pcsrc),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .imem_addr_o     (imem_addr),
    .imem_data_i     (imem_data),
    .imem_valid_i    (imem_valid),
    .pc_o            (pc),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_plus_o  (ifid_pc_plus),
    .ifid_valid_o    (ifid_valid),
    .ifid_rs_o       (ifid_rs),
    .ifid_rt_o       (ifid_rt),
    .fetch_state_o   (fetch_state),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  typedef struct {
    logic        rst, dhz, chz, pcsrc, ivalid;
    logic [15:0] bt, jt, data;
    logic [15:0] e_pc, e_instr, e_pp;
    logic        e_v;
    logic [1:0]  e_st;
    logic [15:0] e_sc, e_fc;
    logic        chk_pp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic d, logic c, logic ps, logic iv,
                              logic [15:0] bt, logic [15:0] jt, logic [15:0] dat,
                              logic [15:0] epc, logic [15:0] ein, logic [15:0] epp,
                              logic ev, logic [1:0] est, logic [15:0] esc,
                              logic [15:0] efc, logic cpp);
    vec_t v;
    v.rst = r; v.dhz = d; v.chz = c; v.pcsrc = ps; v.ivalid = iv;
    v.bt = bt; v.jt = jt; v.data = dat;
    v.e_pc = epc; v.e_instr = ein; v.e_pp = epp; v.e_v = ev; v.e_st = est;
    v.e_sc = esc; v.e_fc = efc; v.chk_pp = cpp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; dhz = v.dhz; chz = v.chz; pcsrc = v.pcsrc;
    imem_valid = v.ivalid; branch_target = v.bt; jump_target = v.jt;
    imem_data = v.data;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [15:0] ein;
    ein = v.e_instr;
    chk({tag, " pc"},    {16'h0, pc},        {16'h0, v.e_pc});
    chk({tag, " addr"},  {16'h0, imem_addr}, {16'h0, v.e_pc});
    chk({tag, " instr"}, {16'h0, ifid_instr},{16'h0, ein});
    if (v.chk_pp) chk({tag, " pcplus"}, {16'h0, ifid_pc_plus}, {16'h0, v.e_pp});
    chk({tag, " valid"}, {31'h0, ifid_valid}, {31'h0, v.e_v});
    chk({tag, " state"}, {30'h0, fetch_state}, {30'h0, v.e_st});
    chk({tag, " rs"},    {29'h0, ifid_rs},   {29'h0, ein[12:10]});
    chk({tag, " rt"},    {29'h0, ifid_rt},   {29'h0, ein[9:7]});
    chk({tag, " stallcnt"}, {16'h0, stall_cnt}, {16'h0, PERF ? v.e_sc : 16'h0});
    chk({tag, " flushcnt"}, {16'h0, flush_cnt}, {16'h0, PERF ? v.e_fc : 16'h0});
  endtask

  localparam logic [1:0] RUN = 2'd0, STL = 2'd1, FLS = 2'd2, WT = 2'd3;

  initial begin
    vec_t v;
    rst = 1'b1; dhz = 1'b0; chz = 1'b0; pcsrc = 1'b0; imem_valid = 1'b0;
    branch_target = '0; jump_target = '0; imem_data = '0;

    //            rst d c ps iv  bt       jt       data     pc       instr    pp       v  st   sc     fc    cpp
    tbl.push_back(mk(1,0,0,0,1, 16'h0,   16'h0,   16'h9999, 16'h0000,16'h0000,16'h0000,0, RUN, 16'd0, 16'd0, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h1111, 16'h0002,16'h1111,16'h0002,1, RUN, 16'd0, 16'd0, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h2222, 16'h0004,16'h2222,16'h0004,1, RUN, 16'd0, 16'd0, 1));
    tbl.push_back(mk(0,1,0,0,1, 16'h0,   16'h0,   16'hAAAA, 16'h0004,16'h2222,16'h0004,1, STL, 16'd1, 16'd0, 1));
    tbl.push_back(mk(0,1,0,0,0, 16'h0,   16'h0,   16'hBBBB, 16'h0004,16'h2222,16'h0004,1, STL, 16'd2, 16'd0, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h3333, 16'h0006,16'h3333,16'h0006,1, RUN, 16'd2, 16'd0, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h4444, 16'h0008,16'h4444,16'h0008,1, RUN, 16'd2, 16'd0, 1));
    tbl.push_back(mk(0,0,0,0,0, 16'h0,   16'h0,   16'hCCCC, 16'h0008,16'h0000,16'h0000,0, WT,  16'd2, 16'd0, 0));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h5555, 16'h000A,16'h5555,16'h000A,1, RUN, 16'd2, 16'd0, 1));
    tbl.push_back(mk(0,1,1,1,1, 16'h0040,16'h0200,16'hDDDD, 16'h0040,16'h0000,16'h0000,0, FLS, 16'd2, 16'd1, 1));
    tbl.push_back(mk(0,0,1,0,1, 16'h0080,16'h0100,16'hEEEE, 16'h0100,16'h0000,16'h0000,0, FLS, 16'd2, 16'd2, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h6666, 16'h0102,16'h6666,16'h0102,1, RUN, 16'd2, 16'd2, 1));
    tbl.push_back(mk(0,0,1,0,0, 16'h0010,16'hFFFE,16'h0,    16'hFFFE,16'h0000,16'h0000,0, FLS, 16'd2, 16'd3, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h7777, 16'h0000,16'h7777,16'h0000,1, RUN, 16'd2, 16'd3, 1));
    tbl.push_back(mk(0,1,0,0,1, 16'h0,   16'h0,   16'h8888, 16'h0000,16'h7777,16'h0000,1, STL, 16'd3, 16'd3, 1));
    tbl.push_back(mk(1,1,0,0,1, 16'h0,   16'h0,   16'h8888, 16'h0000,16'h0000,16'h0000,0, RUN, 16'd0, 16'd0, 1));
    tbl.push_back(mk(0,0,1,1,1, 16'h1235,16'h2000,16'h0,    16'h1235,16'h0000,16'h0000,0, FLS, 16'd0, 16'd1, 1));
    tbl.push_back(mk(0,0,0,0,1, 16'h0,   16'h0,   16'h1E80, 16'h1237,16'h1E80,16'h1237,1, RUN, 16'd0, 16'd1, 1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_vec($sformatf("vec%0d", i), tbl[i]);
      @(negedge clk);
    end

    // Reset wins over a simultaneous redirect.
    v = mk(1,1,1,1,1, 16'h4000,16'h5000,16'hFFFF, 16'h0000,16'h0000,16'h0000,0, RUN, 16'd0, 16'd0, 1);
    drive(v);
    @(posedge clk); #1;
    check_vec("rst_over_chz", v);
    @(negedge clk);

    // Fetch latency: the word present while imem_addr shows A lands in IF/ID
    // with pc_plus A+2 one edge later, over a short run of fetches.
    rst = 1'b0; dhz = 1'b0; chz = 1'b0; imem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = 16'h0000 + 16'(2 * k);
      chk($sformatf("lat%0d addr", k), {16'h0, imem_addr}, {16'h0, a});
      imem_data = 16'hC000 | 16'(k);
      @(posedge clk); #1;
      chk($sformatf("lat%0d instr", k), {16'h0, ifid_instr}, {16'h0, 16'hC000 | 16'(k)});
      chk($sformatf("lat%0d pcplus", k), {16'h0, ifid_pc_plus}, {16'h0, a + 16'd2});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
